// File: rtl/mdu_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_if
//   Handshake bundle between the mul/div sequencer and the multi-cycle
//   multiply and divide units.
//
//   Handshake: a start is a single-cycle pulse from the sequencer that the
//   unit must always take (there is no ready); the unit later answers with a
//   single-cycle done pulse whose result word is valid in that same cycle.
//   The sequencer never issues a new start while a previous one is pending,
//   and it discards any done that it is not currently waiting for.
//
//   Signals:
//     mul_start  sequencer -> multiplier  start pulse
//     mul_done   multiplier -> sequencer  result valid
//     mul_res    multiplier -> sequencer  result word (XLEN)
//     div_start  sequencer -> divider     start pulse
//     div_done   divider -> sequencer     result valid
//     div_res    divider -> sequencer     result word (XLEN)
//
//   Modports: master = sequencer side, slave = unit side.
// ---------------------------------------------------------------------------
interface mdu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_res;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_res;

    modport master (
        output mul_start,
        output div_start,
        input  mul_done,
        input  mul_res,
        input  div_done,
        input  div_res
    );

    modport slave (
        input  mul_start,
        input  div_start,
        output mul_done,
        output mul_res,
        output div_done,
        output div_res
    );
endinterface

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
//   Execute-stage sequencer for the multi-cycle multiply and divide units.
//   Accepts a MUL*/DIV*/REM* instruction from EX, starts the right unit and
//   stalls the front of the pipeline until the result comes back. The RISC-V
//   divide-by-zero and signed-overflow results are produced locally without
//   starting the divider. Results are presented as a registered word plus
//   destination register with a one-cycle valid pulse.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     pipe_flush           pipeline flush; abandons any operation in flight
//     ex_valid, ex_ok      EX holds a valid instruction / no pending trap
//     ex_is_mul_inst       EX instruction is MUL* (wins if both flags set)
//     ex_is_div_inst       EX instruction is DIV*/REM*
//     ex_div_sign          1 = signed divide
//     ex_div_res_sel       0 = quotient, 1 = remainder
//     ex_rs1, ex_rs2       dividend / divisor (XLEN)
//     ex_rd                destination register
//     unit                 start/done/result bundle to the units (master)
//     md_stall             hold PC/IF/ID/EX
//     md_busy              sequencer not idle
//     md_res_valid         one-cycle result-valid pulse
//     md_res, md_rd        result and its destination register
//     md_timeout           one-cycle pulse: unit never answered
// ---------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_flush,
    input  logic                     ex_valid,
    input  logic                     ex_ok,
    input  logic                     ex_is_mul_inst,
    input  logic                     ex_is_div_inst,
    input  logic                     ex_div_sign,
    input  logic                     ex_div_res_sel,
    input  logic [XLEN-1:0]          ex_rs1,
    input  logic [XLEN-1:0]          ex_rs2,
    input  logic [RF_ADDR_WIDTH-1:0] ex_rd,
    mdu_ctrl_if.master               unit,
    output logic                     md_stall,
    output logic                     md_busy,
    output logic                     md_res_valid,
    output logic [XLEN-1:0]          md_res,
    output logic [RF_ADDR_WIDTH-1:0] md_rd,
    output logic                     md_timeout
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [XLEN-1:0]          res_q, res_d;
    logic [RF_ADDR_WIDTH-1:0] rd_q, rd_d;

    logic accept;
    logic take_mul;
    logic take_div;
    logic div_by_zero;
    logic div_ovf;
    logic div_fast;
    logic in_wait;
    logic unit_done;
    logic cnt_last;

    // Acceptance is only ever evaluated in IDLE, so a start can never be
    // issued while busy.
    assign accept   = (state_q == S_IDLE) & ex_valid & ex_ok & ~pipe_flush &
                      (ex_is_mul_inst | ex_is_div_inst);
    assign take_mul = accept & ex_is_mul_inst;
    assign take_div = accept & ~ex_is_mul_inst;

    // Cases with an architecturally defined result that skip the divider.
    assign div_by_zero = (ex_rs2 == '0);
    assign div_ovf     = ex_div_sign & (ex_rs1 == INT_MIN) & (ex_rs2 == '1);
    assign div_fast    = div_by_zero | div_ovf;

    assign in_wait   = (state_q == S_MUL_WAIT) | (state_q == S_DIV_WAIT);
    // Only the done of the unit being waited on counts.
    assign unit_done = ((state_q == S_MUL_WAIT) & unit.mul_done) |
                       ((state_q == S_DIV_WAIT) & unit.div_done);
    assign cnt_last  = (cnt_q == CNT_LAST);

    assign unit.mul_start = take_mul;
    assign unit.div_start = take_div & ~div_fast;

    // Stall drops in DONE so the instruction leaves EX carrying the result.
    assign md_stall     = accept | in_wait;
    assign md_busy      = (state_q != S_IDLE);
    assign md_res_valid = (state_q == S_DONE);
    assign md_res       = res_q;
    assign md_rd        = rd_q;
    // A flush or a same-cycle done takes priority over the abort.
    assign md_timeout   = in_wait & ~pipe_flush & ~unit_done & cnt_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (take_mul) begin
                    rd_d    = ex_rd;
                    state_d = S_MUL_WAIT;
                end else if (take_div) begin
                    rd_d = ex_rd;
                    if (div_by_zero) begin
                        res_d   = ex_div_res_sel ? ex_rs1 : '1;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        res_d   = ex_div_res_sel ? '0 : ex_rs1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV_WAIT;
                    end
                end
            end
            S_MUL_WAIT, S_DIV_WAIT: begin
                if (pipe_flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (unit_done) begin
                    res_d   = (state_q == S_MUL_WAIT) ? unit.mul_res : unit.div_res;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
//   Self-checking bench for mdu_ctrl. A transaction-level model (operation in
//   flight, its age in wait cycles, and a queue of results owed to the
//   pipeline) predicts every output on every cycle. Directed scenarios pin
//   literal values; a randomized phase exercises everything together.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int TOUT = 8;

    logic            clk;
    logic            rst_n;
    logic            pipe_flush;
    logic            ex_valid;
    logic            ex_ok;
    logic            ex_is_mul_inst;
    logic            ex_is_div_inst;
    logic            ex_div_sign;
    logic            ex_div_res_sel;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [RW-1:0]   ex_rd;
    logic            md_stall;
    logic            md_busy;
    logic            md_res_valid;
    logic [XLEN-1:0] md_res;
    logic [RW-1:0]   md_rd;
    logic            md_timeout;

    mdu_ctrl_if #(.XLEN(XLEN)) u_if ();

    mdu_ctrl #(
        .XLEN          (XLEN),
        .RF_ADDR_WIDTH (RW),
        .TIMEOUT       (TOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_flush     (pipe_flush),
        .ex_valid       (ex_valid),
        .ex_ok          (ex_ok),
        .ex_is_mul_inst (ex_is_mul_inst),
        .ex_is_div_inst (ex_is_div_inst),
        .ex_div_sign    (ex_div_sign),
        .ex_div_res_sel (ex_div_res_sel),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .unit           (u_if),
        .md_stall       (md_stall),
        .md_busy        (md_busy),
        .md_res_valid   (md_res_valid),
        .md_res         (md_res),
        .md_rd          (md_rd),
        .md_timeout     (md_timeout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 = nothing in flight, 1 = waiting on multiplier, 2 = on divider
    int                 m_unit  = 0;
    int                 m_age   = 0;
    bit                 m_pulse = 0;
    logic [RW-1:0]      m_rd    = '0;
    logic [XLEN-1:0]    m_cur   = '0;
    logic [RW+XLEN-1:0] exp_q[$];

    // values sampled in the most recent checked cycle
    logic s_ms, s_ds, s_stall, s_busy, s_valid, s_to;
    logic [XLEN-1:0] s_res;
    logic [RW-1:0]   s_rd;

    // per-scenario event counts
    int w_ms, w_ds, w_stall, w_valid, w_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_win();
        w_ms = 0; w_ds = 0; w_stall = 0; w_valid = 0; w_to = 0;
    endtask

    task automatic model_reset();
        m_unit = 0; m_age = 0; m_pulse = 0; m_rd = '0; m_cur = '0;
        exp_q.delete();
    endtask

    // RISC-V divide results that need no divider
    function automatic bit is_special(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      input logic sgn);
        return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [XLEN-1:0] special_res(input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b,
                                                    input logic sel);
        if (b == 32'h0) return sel ? a : 32'hFFFF_FFFF;
        return sel ? 32'h0 : a;
    endfunction

    task automatic idle_inputs();
        pipe_flush = 0; ex_valid = 0; ex_ok = 1;
        ex_is_mul_inst = 0; ex_is_div_inst = 0; ex_div_sign = 0; ex_div_res_sel = 0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        u_if.mul_done = 0; u_if.mul_res = '0; u_if.div_done = 0; u_if.div_res = '0;
    endtask

    task automatic drive_inst(input logic mul, input logic div, input logic sgn, input logic sel,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [RW-1:0] rd);
        ex_valid = 1; ex_ok = 1; ex_is_mul_inst = mul; ex_is_div_inst = div;
        ex_div_sign = sgn; ex_div_res_sel = sel; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    endtask

    // Compare process: called once per cycle with inputs already driven.
    task automatic check_cycle();
        bit acc, done, e_ms, e_ds, e_stall, e_busy, e_valid, e_to;
        logic [RW+XLEN-1:0] ent;
        @(negedge clk);
        s_ms = u_if.mul_start; s_ds = u_if.div_start; s_stall = md_stall; s_busy = md_busy;
        s_valid = md_res_valid; s_to = md_timeout; s_res = md_res; s_rd = md_rd;
        acc = 0; done = 0;
        e_ms = 0; e_ds = 0; e_stall = 0; e_busy = 0; e_valid = 0; e_to = 0;
        if (m_pulse) begin
            e_busy = 1; e_valid = 1;
        end else if (m_unit != 0) begin
            e_busy  = 1; e_stall = 1;
            done    = (m_unit == 1) ? u_if.mul_done : u_if.div_done;
            e_to    = !pipe_flush && !done && (m_age == TOUT);
        end else begin
            acc     = ex_valid && ex_ok && !pipe_flush && (ex_is_mul_inst || ex_is_div_inst);
            e_stall = acc;
            e_ms    = acc && ex_is_mul_inst;
            e_ds    = acc && !ex_is_mul_inst && !is_special(ex_rs1, ex_rs2, ex_div_sign);
        end
        chk("mul_start", s_ms, e_ms);
        chk("div_start", s_ds, e_ds);
        chk("md_stall", s_stall, e_stall);
        chk("md_busy", s_busy, e_busy);
        chk("md_res_valid", s_valid, e_valid);
        chk("md_timeout", s_to, e_to);
        if (e_valid) begin
            ent = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("md_res", s_res, ent[XLEN-1:0]);
            chk("md_rd", s_rd, ent[RW+XLEN-1:XLEN]);
            m_cur = ent[XLEN-1:0];
        end else begin
            chk("md_res_hold", s_res, m_cur);
        end
        w_ms += s_ms; w_ds += s_ds; w_stall += s_stall; w_valid += s_valid; w_to += s_to;
        // advance the model
        if (m_pulse) begin
            m_pulse = 0;
        end else if (m_unit != 0) begin
            if (pipe_flush) begin
                m_unit = 0;
            end else if (done) begin
                exp_q.push_back({m_rd, (m_unit == 1) ? u_if.mul_res : u_if.div_res});
                m_unit  = 0;
                m_pulse = 1;
            end else if (e_to) begin
                m_unit = 0;
            end else begin
                m_age++;
            end
        end else if (acc) begin
            if (ex_is_mul_inst) begin
                m_unit = 1; m_age = 1; m_rd = ex_rd;
            end else if (is_special(ex_rs1, ex_rs2, ex_div_sign)) begin
                exp_q.push_back({ex_rd, special_res(ex_rs1, ex_rs2, ex_div_res_sel)});
                m_pulse = 1;
            end else begin
                m_unit = 2; m_age = 1; m_rd = ex_rd;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        clr_win();
        #3;
        chk("rst_mul_start", u_if.mul_start, 0);
        chk("rst_div_start", u_if.div_start, 0);
        chk("rst_stall", md_stall, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_valid", md_res_valid, 0);
        chk("rst_res", md_res, 0);
        chk("rst_rd", md_rd, 0);
        chk("rst_timeout", md_timeout, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        check_cycle();

        // multiply: 7*6 = 42 returned on the 3rd wait cycle
        clr_win();
        drive_inst(1, 0, 0, 0, 32'd7, 32'd6, 5'd5);
        check_cycle();
        chk("mul_accept_start", s_ms, 1);
        check_cycle();
        check_cycle();
        u_if.mul_done = 1; u_if.mul_res = 32'd42;
        check_cycle();
        u_if.mul_done = 0;
        check_cycle();
        chk("mul_valid", s_valid, 1);
        chk("mul_res_42", s_res, 32'd42);
        chk("mul_rd", s_rd, 5);
        chk("mul_stall_cycles", w_stall, 4);
        chk("mul_start_count", w_ms, 1);
        ex_valid = 0;
        check_cycle();
        chk("mul_back_idle", s_busy, 0);

        // divide by zero, quotient then remainder
        clr_win();
        drive_inst(0, 1, 0, 0, 32'h1234, 32'h0, 5'd3);
        check_cycle();
        ex_valid = 0;
        check_cycle();
        chk("dbz_q_valid", s_valid, 1);
        chk("dbz_q_res", s_res, 32'hFFFF_FFFF);
        drive_inst(0, 1, 0, 1, 32'h1234, 32'h0, 5'd4);
        check_cycle();
        ex_valid = 0;
        check_cycle();
        chk("dbz_r_res", s_res, 32'h1234);
        chk("dbz_r_rd", s_rd, 4);
        chk("dbz_no_div_start", w_ds, 0);

        // signed overflow
        clr_win();
        drive_inst(0, 1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        check_cycle();
        ex_valid = 0;
        check_cycle();
        chk("ovf_q_res", s_res, 32'h8000_0000);
        drive_inst(0, 1, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        check_cycle();
        ex_valid = 0;
        check_cycle();
        chk("ovf_r_res", s_res, 32'h0);
        chk("ovf_no_div_start", w_ds, 0);
        chk("ovf_valid_count", w_valid, 2);

        // flush on DIV_WAIT cycle 5 with a coincident div_done
        drive_inst(0, 1, 1, 0, 32'd100, 32'd7, 5'd9);
        check_cycle();
        chk("flush_div_start", s_ds, 1);
        clr_win();
        for (int i = 0; i < 4; i++) check_cycle();
        pipe_flush = 1; u_if.div_done = 1; u_if.div_res = 32'd14;
        check_cycle();
        pipe_flush = 0; u_if.div_done = 0;
        drive_inst(1, 0, 0, 0, 32'd3, 32'd4, 5'd11);
        check_cycle();
        chk("flush_then_mul_start", s_ms, 1);
        chk("flush_no_valid", w_valid, 0);
        u_if.mul_done = 1; u_if.mul_res = 32'd12;
        check_cycle();
        u_if.mul_done = 0;
        check_cycle();
        chk("post_flush_res", s_res, 32'd12);
        chk("post_flush_rd", s_rd, 11);
        ex_valid = 0;
        check_cycle();

        // hung divider
        drive_inst(0, 1, 0, 0, 32'd50, 32'd5, 5'd2);
        check_cycle();
        clr_win();
        for (int i = 0; i < TOUT - 1; i++) check_cycle();
        chk("hung_no_early_timeout", w_to, 0);
        check_cycle();
        chk("hung_timeout_8th", s_to, 1);
        chk("hung_stall_8th", s_stall, 1);
        ex_valid = 0;
        check_cycle();
        chk("hung_stall_drop", s_stall, 0);
        chk("hung_idle", s_busy, 0);
        chk("hung_no_valid", w_valid, 0);

        // ex_ok low blocks acceptance
        clr_win();
        drive_inst(0, 1, 0, 0, 32'd9, 32'd3, 5'd1);
        ex_ok = 0;
        check_cycle();
        check_cycle();
        chk("exok_no_div_start", w_ds, 0);
        chk("exok_no_stall", w_stall, 0);
        chk("exok_not_busy", s_busy, 0);
        idle_inputs();

        // reset in the middle of a divide
        drive_inst(0, 1, 0, 0, 32'd77, 32'd3, 5'd13);
        check_cycle();
        check_cycle();
        ex_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_busy", md_busy, 0);
        chk("midrst_stall", md_stall, 0);
        chk("midrst_res", md_res, 0);
        chk("midrst_rd", md_rd, 0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        check_cycle();

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_ok          = ($urandom_range(0, 9) != 0);
            pipe_flush     = ($urandom_range(0, 24) == 0);
            ex_is_mul_inst = 1'($urandom_range(0, 1));
            ex_is_div_inst = 1'($urandom_range(0, 1));
            ex_div_sign    = 1'($urandom_range(0, 1));
            ex_div_res_sel = 1'($urandom_range(0, 1));
            ex_rs1         = ($urandom_range(0, 2) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       ex_rs2 = 32'h0;
                1:       ex_rs2 = 32'hFFFF_FFFF;
                2:       ex_rs2 = 32'($urandom_range(1, 15));
                default: ex_rs2 = $urandom;
            endcase
            ex_rd          = 5'($urandom_range(0, 31));
            u_if.mul_done  = ($urandom_range(0, 5) == 0);
            u_if.mul_res   = $urandom;
            u_if.div_done  = ($urandom_range(0, 5) == 0);
            u_if.div_res   = $urandom;
            check_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
